// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg: shared types and constants for the writeback stage.
//   XLEN     - integer datapath width
//   AW       - register-file address width
//   wb_req_t - one register-file write request (destination + data)
//   REG_ZERO - architectural x0, which is never written
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo: small synchronous FIFO buffering long-latency writeback requests.
// The head entry is read combinationally from storage; a pushed entry becomes
// visible at the head only from the following cycle (no fall-through).
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   push_i           write push_data_i at the tail (ignored when full)
//   push_data_i      request to enqueue
//   pop_i            drop the head entry (ignored when empty)
//   head_o           current head entry
//   full_o, empty_o  occupancy flags
//   count_o          number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  wb_req_t                  push_data_i,
    input  logic                     pop_i,
    output wb_req_t                  head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~full_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage: writeback stage owning the integer register file's write port.
// Merges the in-order single-cycle pipe (priority) with long-latency results
// (load/mul/div) buffered in a FIFO, and drives a registered write port.
// A starvation guard stalls the pipe for one cycle when the LL FIFO has been
// full and blocked for STARVE_MAX consecutive cycles.
//
// Build option: define WB_FWD_EN to bypass the in-flight register-file write
// onto rs1_data_o/rs2_data_o; otherwise those outputs pass the raw read data.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   pipe_valid_i/_rd_addr_i/_rd_data_i single-cycle pipe result
//   stall_o                            pipe must hold its request (registered)
//   ll_valid_i/ll_ready_o              LL handshake
//   ll_rd_addr_i/ll_rd_data_i          LL result
//   rd_wren_o/rd_addr_o/rd_data_o      register-file write port
//   rs1/rs2_addr_i, rs1/rs2_rf_data_i  decode read address / raw RF data
//   rs1/rs2_data_o                     operand data to decode
//   ll_count_o                         LL FIFO occupancy
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int LL_DEPTH   = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        pipe_valid_i,
    input  logic [AW-1:0]               pipe_rd_addr_i,
    input  logic [XLEN-1:0]             pipe_rd_data_i,
    output logic                        stall_o,
    input  logic                        ll_valid_i,
    output logic                        ll_ready_o,
    input  logic [AW-1:0]               ll_rd_addr_i,
    input  logic [XLEN-1:0]             ll_rd_data_i,
    output logic                        rd_wren_o,
    output logic [AW-1:0]               rd_addr_o,
    output logic [XLEN-1:0]             rd_data_o,
    input  logic [AW-1:0]               rs1_addr_i,
    input  logic [AW-1:0]               rs2_addr_i,
    input  logic [XLEN-1:0]             rs1_rf_data_i,
    input  logic [XLEN-1:0]             rs2_rf_data_i,
    output logic [XLEN-1:0]             rs1_data_o,
    output logic [XLEN-1:0]             rs2_data_o,
    output logic [$clog2(LL_DEPTH):0]   ll_count_o
);

    import wb_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    wb_req_t         ll_req;
    wb_req_t         head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            pipe_req;

    logic            stall_q, stall_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            rd_wren_q, rd_wren_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    // x0 requests are swallowed here: pipe x0 never claims the port, and an
    // LL x0 result completes its handshake without occupying a FIFO slot.
    assign pipe_req   = pipe_valid_i & (pipe_rd_addr_i != REG_ZERO) & ~stall_q;
    assign ll_ready_o = ~fifo_full;
    assign push       = ll_valid_i & ll_ready_o & (ll_rd_addr_i != REG_ZERO);
    assign pop        = ~pipe_req & ~fifo_empty;
    assign ll_req     = '{addr: ll_rd_addr_i, data: ll_rd_data_i};

    wb_fifo #(
        .DEPTH       (LL_DEPTH)
    ) u_ll_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (ll_req),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (ll_count_o)
    );

    // Write-port arbitration; address/data hold their last value when idle.
    always_comb begin
        rd_wren_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (pipe_req) begin
            rd_wren_d = 1'b1;
            rd_addr_d = pipe_rd_addr_i;
            rd_data_d = pipe_rd_data_i;
        end else if (pop) begin
            rd_wren_d = 1'b1;
            rd_addr_d = head.addr;
            rd_data_d = head.data;
        end
    end

    // Starvation guard. stall is raised in the same edge that the counter
    // reaches the limit, so the stalled cycle pops the head and the stall
    // clears right after. Clearing on empty keeps the pipe from ever being
    // held with nothing to drain.
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
            stall_d  = 1'b0;
        end else if (fifo_full && pipe_req) begin
            if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
            if (starve_d == STARVE_LIM) stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q   <= 1'b0;
            starve_q  <= '0;
            rd_wren_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            stall_q   <= stall_d;
            starve_q  <= starve_d;
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign stall_o   = stall_q;
    assign rd_wren_o = rd_wren_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;

`ifdef WB_FWD_EN
    // The register file does not bypass its own write to its read ports, so
    // the write being committed this cycle is forwarded here.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [AW-1:0]   rs_addr,
        input logic [XLEN-1:0] rs_rf_data,
        input logic            wr_en,
        input logic [AW-1:0]   wr_addr,
        input logic [XLEN-1:0] wr_data
    );
        if (rs_addr == REG_ZERO)                 return '0;
        else if (wr_en && (wr_addr == rs_addr))  return wr_data;
        else                                     return rs_rf_data;
    endfunction

    assign rs1_data_o = fwd_sel(rs1_addr_i, rs1_rf_data_i, rd_wren_q, rd_addr_q, rd_data_q);
    assign rs2_data_o = fwd_sel(rs2_addr_i, rs2_rf_data_i, rd_wren_q, rd_addr_q, rd_data_q);
`else
    // Without forwarding, decode stalls on a match; read addresses are unused.
    logic unused_rs_addr;
    assign unused_rs_addr = ^{rs1_addr_i, rs2_addr_i};
    assign rs1_data_o     = rs1_rf_data_i;
    assign rs2_data_o     = rs2_rf_data_i;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int SMAX  = 4;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b1;
    logic            pipe_valid_i = 1'b0;
    logic [AW-1:0]   pipe_rd_addr_i = '0;
    logic [XLEN-1:0] pipe_rd_data_i = '0;
    logic            stall_o;
    logic            ll_valid_i = 1'b0;
    logic            ll_ready_o;
    logic [AW-1:0]   ll_rd_addr_i = '0;
    logic [XLEN-1:0] ll_rd_data_i = '0;
    logic            rd_wren_o;
    logic [AW-1:0]   rd_addr_o;
    logic [XLEN-1:0] rd_data_o;
    logic [AW-1:0]   rs1_addr_i = '0;
    logic [AW-1:0]   rs2_addr_i = '0;
    logic [XLEN-1:0] rs1_rf_data_i = '0;
    logic [XLEN-1:0] rs2_rf_data_i = '0;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic [$clog2(DEPTH):0] ll_count_o;

    wb_stage #(
        .XLEN(XLEN), .AW(AW), .LL_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .pipe_valid_i   (pipe_valid_i),
        .pipe_rd_addr_i (pipe_rd_addr_i),
        .pipe_rd_data_i (pipe_rd_data_i),
        .stall_o        (stall_o),
        .ll_valid_i     (ll_valid_i),
        .ll_ready_o     (ll_ready_o),
        .ll_rd_addr_i   (ll_rd_addr_i),
        .ll_rd_data_i   (ll_rd_data_i),
        .rd_wren_o      (rd_wren_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_o      (rd_data_o),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_addr_i     (rs2_addr_i),
        .rs1_rf_data_i  (rs1_rf_data_i),
        .rs2_rf_data_i  (rs2_rf_data_i),
        .rs1_data_o     (rs1_data_o),
        .rs2_data_o     (rs2_data_o),
        .ll_count_o     (ll_count_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of pending LL writes plus a run-length count
    // of cycles the full queue was passed over in favour of the pipe.
    logic [AW+XLEN-1:0] mq[$];
    logic            m_wren  = 1'b0;
    logic [AW-1:0]   m_addr  = '0;
    logic [XLEN-1:0] m_data  = '0;
    logic            m_stall = 1'b0;
    int              m_blk   = 0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            m_wren  <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_stall <= 1'b0;
            m_blk   <= 0;
        end else begin
            automatic int sz = mq.size();
            automatic bit preq = pipe_valid_i && (pipe_rd_addr_i != 0) && !m_stall;
            automatic bit popped = 1'b0;
            automatic logic [AW+XLEN-1:0] e;
            if (preq) begin
                m_wren <= 1'b1;
                m_addr <= pipe_rd_addr_i;
                m_data <= pipe_rd_data_i;
            end else if (sz > 0) begin
                e = mq.pop_front();
                popped = 1'b1;
                m_wren <= 1'b1;
                m_addr <= e[AW+XLEN-1:XLEN];
                m_data <= e[XLEN-1:0];
            end else begin
                m_wren <= 1'b0;
            end
            if (ll_valid_i && (sz < DEPTH) && (ll_rd_addr_i != 0))
                mq.push_back({ll_rd_addr_i, ll_rd_data_i});
            if (popped) begin
                m_blk   <= 0;
                m_stall <= 1'b0;
            end else if (sz == DEPTH && preq) begin
                m_blk <= m_blk + 1;
                if (m_blk + 1 >= SMAX) m_stall <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cmp_wren", rd_wren_o, m_wren);
        if (m_wren) begin
            chk("cmp_addr", rd_addr_o, m_addr);
            chk("cmp_data", rd_data_o, m_data);
        end
        chk("cmp_stall", stall_o, m_stall);
        chk("cmp_ready", ll_ready_o, mq.size() < DEPTH);
        chk("cmp_count", ll_count_o, mq.size());
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        pipe_valid_i   = 1'b0;
        pipe_rd_addr_i = '0;
        pipe_rd_data_i = '0;
        ll_valid_i     = 1'b0;
        ll_rd_addr_i   = '0;
        ll_rd_data_i   = '0;
    endtask

    int got[$];

    initial begin
        #1 rst_ni = 1'b0;
        repeat (2) cyc();
        rst_ni = 1'b1;

        // Reset state
        chk("rst_wren",  rd_wren_o, 0);
        chk("rst_addr",  rd_addr_o, 0);
        chk("rst_data",  rd_data_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_ready", ll_ready_o, 1);
        chk("rst_count", ll_count_o, 0);

        // Pipe x5 write: visible exactly one cycle later, for one cycle
        pipe_valid_i = 1'b1; pipe_rd_addr_i = 5; pipe_rd_data_i = 32'hDEADBEEF;
        cyc();
        idle_inputs();
        chk("p5_wren", rd_wren_o, 1);
        chk("p5_addr", rd_addr_o, 5);
        chk("p5_data", rd_data_o, 32'hDEADBEEF);
        cyc();
        chk("p5_off", rd_wren_o, 0);

        // LL x7 with pipe idle: accepted at N, written at N+2
        ll_valid_i = 1'b1; ll_rd_addr_i = 7; ll_rd_data_i = 32'h12345678;
        chk("ll7_ready", ll_ready_o, 1);
        cyc();
        idle_inputs();
        chk("ll7_cnt1", ll_count_o, 1);
        chk("ll7_nowr", rd_wren_o, 0);
        cyc();
        chk("ll7_cnt0", ll_count_o, 0);
        chk("ll7_wren", rd_wren_o, 1);
        chk("ll7_addr", rd_addr_o, 7);
        chk("ll7_data", rd_data_o, 32'h12345678);
        cyc();
        chk("ll7_off", rd_wren_o, 0);

        // Starvation: pipe busy every cycle while LL fills the FIFO
        for (int i = 0; i < 4; i++) begin
            pipe_valid_i = 1'b1; pipe_rd_addr_i = 10; pipe_rd_data_i = 32'h1000 + i;
            ll_valid_i = 1'b1; ll_rd_addr_i = AW'(i + 1); ll_rd_data_i = 32'hC0DE0000 + i + 1;
            cyc();
        end
        ll_valid_i = 1'b0;
        chk("st_full_ready", ll_ready_o, 0);
        chk("st_full_count", ll_count_o, 4);
        chk("st_nostall0", stall_o, 0);
        for (int i = 0; i < 3; i++) begin
            pipe_rd_data_i = 32'h2000 + i;
            cyc();
        end
        chk("st_nostall3", stall_o, 0);
        cyc();
        chk("st_stall", stall_o, 1);
        pipe_valid_i = 1'b0;
        cyc();
        chk("st_x1_wren", rd_wren_o, 1);
        chk("st_x1_addr", rd_addr_o, 1);
        chk("st_x1_data", rd_data_o, 32'hC0DE0001);
        chk("st_unstall", stall_o, 0);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (rd_wren_o) got.push_back(int'(rd_addr_o));
        end
        chk("drain_n", got.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("drain%0d", i), (i < got.size()) ? got[i] : 0, i + 2);

        // x0 filter on both sources
        pipe_valid_i = 1'b1; pipe_rd_addr_i = 0; pipe_rd_data_i = 32'hFFFFFFFF;
        ll_valid_i = 1'b1; ll_rd_addr_i = 0; ll_rd_data_i = 32'hFFFFFFFF;
        chk("x0_ready", ll_ready_o, 1);
        cyc();
        idle_inputs();
        chk("x0_wren", rd_wren_o, 0);
        chk("x0_count", ll_count_o, 0);
        cyc();
        chk("x0_wren2", rd_wren_o, 0);

        // Read-port bypass
        pipe_valid_i = 1'b1; pipe_rd_addr_i = 9; pipe_rd_data_i = 32'hA5A5A5A5;
        cyc();
        idle_inputs();
        rs1_addr_i = 9; rs1_rf_data_i = 32'h0;
        rs2_addr_i = 0; rs2_rf_data_i = 32'h11111111;
        #1;
`ifdef WB_FWD_EN
        chk("fwd_rs1", rs1_data_o, 32'hA5A5A5A5);
        chk("fwd_rs2_x0", rs2_data_o, 32'h0);
`else
        chk("fwd_rs1", rs1_data_o, 32'h0);
        chk("fwd_rs2_x0", rs2_data_o, 32'h11111111);
`endif
        cyc();
        rs1_rf_data_i = 32'h33333333;
        #1;
        chk("fwd_rs1_idle", rs1_data_o, 32'h33333333);
        rs1_addr_i = 0; rs1_rf_data_i = 0; rs2_rf_data_i = 0;

        // Reset with three LL entries buffered
        for (int i = 0; i < 3; i++) begin
            pipe_valid_i = 1'b1; pipe_rd_addr_i = 11; pipe_rd_data_i = 32'h3000 + i;
            ll_valid_i = 1'b1; ll_rd_addr_i = AW'(20 + i); ll_rd_data_i = 32'h4000 + i;
            cyc();
        end
        idle_inputs();
        chk("mid_count3", ll_count_o, 3);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_count", ll_count_o, 0);
        chk("mid_rst_ready", ll_ready_o, 1);
        chk("mid_rst_wren", rd_wren_o, 0);
        chk("mid_rst_stall", stall_o, 0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("post_rst_wren%0d", i), rd_wren_o, 0);
            chk($sformatf("post_rst_count%0d", i), ll_count_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
